way_bits_array: RTL and testbench
=================================

// Module: way_bits_array
// PURPOSE
//  Parametrised per-set/per-way status-bit store (valid, dirty, lock...) for set-assoc L1 tag path.
//  1 write port with per-way mask, 1 registered read port with write-first bypass, free-way finder.
//  Built-in clear engine sweeps every set to zero after reset or on clr_req; no single-cycle bulk clear.
// PARAMETERS
//  SETS   8192             number of sets (rows); need not be a power of 2
//  WAYS   4                ways per set
//  BITS   1                status bits per way; bit[0] of each way is its valid bit
//  IDX_W  $clog2(SETS)     index width (derived, do not override)
// PORTS
//  clk          in   1            clock, all state updates on rising edge
//  reset_n      in   1            asynchronous, active-low reset
//  rd_en        in   1            read request, sampled at edge
//  rd_index     in   IDX_W        set to read
//  rd_q         out  WAYS*BITS    row read; way w occupies [w*BITS +: BITS]
//  rd_valid     out  1            1-cycle pulse, rd_q holds the data for this read
//  rd_free_way  out  WAYS         one-hot lowest way in rd_q with valid bit 0; 0 if none
//  rd_full      out  1            all valid bits in rd_q set
//  wr_en        in   1            write request
//  wr_index     in   IDX_W        set to write
//  wr_way_mask  in   WAYS         ways to update (multi-hot allowed)
//  wr_data      in   WAYS*BITS    new bits, same layout as rd_q
//  clr_req      in   1            start a full clear sweep
//  busy         out  1            clear sweep in progress; rd/wr ignored
//  clr_done     out  1            1-cycle pulse on the final sweep write
// BEHAVIOUR
//  Reset (reset_n=0, async): state=CLEAR, clr_ptr=0, busy=1, rd_q=0, rd_valid=0, clr_done=0.
//  FSM states: CLEAR, IDLE.
//   CLEAR: each cycle write row clr_ptr = 0, clr_ptr++. At clr_ptr==SETS-1: write, clr_done=1,
//    state->IDLE, busy=0 next cycle. Sweep length = SETS cycles after reset_n rises.
//   IDLE: clr_req=1 -> CLEAR, clr_ptr=0, busy=1 next cycle. clr_req in CLEAR is ignored (no restart).
//  Reset mid-sweep: restarts sweep from 0; partial progress discarded.
//  Write (IDLE, wr_en=1): at edge, for each way w with wr_way_mask[w]=1 row[wr_index] way w <= wr_data
//   way w; unmasked ways unchanged. wr_en with mask 0 is a no-op. wr_en while busy: dropped silently.
//  Read (IDLE, rd_en=1): rd_q = row[rd_index] on next edge, rd_valid=1 for exactly that cycle.
//   Same-cycle wr to same index: rd_q returns post-write value (write-first), per masked way.
//   rd_en=0: rd_q holds last value, rd_valid=0. rd_en while busy: dropped, rd_valid stays 0.
//   rd_en on the edge CLEAR->IDLE (busy still 1) is dropped.
//  rd_free_way/rd_full: combinational from rd_q valid bits only; lowest index wins.
//  rd_index/wr_index >= SETS: undefined, assertion fires in sim.
//  Clear-engine writes have priority over all port writes; only one storage write per cycle.
// STRUCTURE
//  way_bits_pkg: state enum {CLEAR, IDLE}; function first_zero_onehot(valid[WAYS]) -> WAYS;
//   helper to extract valid bits from a WAYS*BITS row.
//  Sub-module way_bits_mem: SETS x WAYS*BITS storage, 1W (per-way bit mask) / 1R sync, write-first;
//   isolated for later macro swap. Top holds FSM, clr_ptr, write mux, free-way logic.
// TESTING (SETS=16, WAYS=4, BITS=1 unless noted)
//  1 reset_n low->high -> busy=1 for 16 cycles, clr_done pulses on 16th, reads of idx 0..15 give 4'b0000.
//  2 wr idx5 mask 0100 data 1111; rd idx5 -> rd_q=0100; wr idx5 mask 0001 data 0001; rd -> 0101.
//  3 same cycle wr idx3 mask 1000 data 1000 + rd idx3 -> next cycle rd_q=1000, rd_valid=1.
//  4 row 0111 -> rd_free_way=1000, rd_full=0; row 1111 -> rd_free_way=0000, rd_full=1.
//  5 fill rows, clr_req -> busy; wr/rd issued during busy dropped (rd_valid=0); after clr_done all rows 0.
//  6 reset_n low at clr_ptr=7, release -> sweep restarts at 0, busy 16 full cycles; BITS=2 rerun of 2.

Source files
------------

// File: rtl/way_bits_array_pkg.sv
// Shared constants and helpers for the per-set/per-way status-bit store.
// Helpers work on fixed maximum widths so any WAYS/BITS instance can call them.
package way_bits_array_pkg;

    localparam int MAX_WAYS = 32;
    localparam int MAX_ROW  = 256;

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] IDLE  = 1'b1;

    // bit[0] of each way is its valid bit
    function automatic logic [MAX_WAYS-1:0] row_valid(input logic [MAX_ROW-1:0] row, input int bits);
        logic [MAX_WAYS-1:0] v;
        v = '0;
        for (int w = 0; w < MAX_WAYS; w++)
            if (w * bits < MAX_ROW) v[w] = row[w*bits];
        return v;
    endfunction

    // Ways above 'ways' read as occupied, so the all-valid case wraps to zero.
    function automatic logic [MAX_WAYS-1:0] first_zero_onehot(input logic [MAX_WAYS-1:0] valid, input int ways);
        logic [MAX_WAYS-1:0] v;
        for (int i = 0; i < MAX_WAYS; i++)
            v[i] = (i < ways) ? valid[i] : 1'b1;
        return ~v & (v + MAX_WAYS'(1));
    endfunction

endpackage

// File: rtl/way_bits_array_if.sv
// Read, write and clear-control bundle of the way-bits array.
interface way_bits_array_if #(
    parameter int WAYS  = 4,
    parameter int BITS  = 1,
    parameter int IDX_W = 13
);
    logic                   rd_en;
    logic [IDX_W-1:0]       rd_index;
    logic [WAYS*BITS-1:0]   rd_q;
    logic                   rd_valid;
    logic [WAYS-1:0]        rd_free_way;
    logic                   rd_full;
    logic                   wr_en;
    logic [IDX_W-1:0]       wr_index;
    logic [WAYS-1:0]        wr_way_mask;
    logic [WAYS*BITS-1:0]   wr_data;
    logic                   clr_req;
    logic                   busy;
    logic                   clr_done;

    modport master (
        output rd_en, rd_index, wr_en, wr_index, wr_way_mask, wr_data, clr_req,
        input  rd_q, rd_valid, rd_free_way, rd_full, busy, clr_done
    );

    modport slave (
        input  rd_en, rd_index, wr_en, wr_index, wr_way_mask, wr_data, clr_req,
        output rd_q, rd_valid, rd_free_way, rd_full, busy, clr_done
    );
endinterface

// File: rtl/way_bits_array_mem.sv
// SETS x WAYS*BITS storage: one per-way-masked write port, one registered read port.
// Kept free of control logic so it can be replaced by a memory macro.
module way_bits_mem #(
    parameter int SETS  = 8192,
    parameter int WAYS  = 4,
    parameter int BITS  = 1,
    parameter int IDX_W = $clog2(SETS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [IDX_W-1:0]     wr_index,
    input  logic [WAYS-1:0]      wr_mask,
    input  logic [WAYS*BITS-1:0] wr_data,
    input  logic                 re,
    input  logic [IDX_W-1:0]     rd_index,
    output logic [WAYS*BITS-1:0] rd_data
);
    localparam int ROW_W = WAYS * BITS;

    logic [ROW_W-1:0] mem [SETS];
    logic [ROW_W-1:0] bmask;
    logic [ROW_W-1:0] rd_row;
    logic [ROW_W-1:0] rd_next;

    for (genvar w = 0; w < WAYS; w++) begin : g_mask
        assign bmask[w*BITS +: BITS] = {BITS{wr_mask[w]}};
    end

    always_ff @(posedge clk) begin
        if (we)
            for (int b = 0; b < ROW_W; b++)
                if (bmask[b]) mem[wr_index][b] <= wr_data[b];
    end

    // Write-first: a same-index write shows up in this read, masked ways only
    assign rd_row  = mem[rd_index];
    assign rd_next = (we && rd_index == wr_index) ? ((rd_row & ~bmask) | (wr_data & bmask)) : rd_row;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rd_data <= '0;
        else if (re) rd_data <= rd_next;
    end
endmodule

// File: rtl/way_bits_array.sv
// Per-set/per-way status-bit store with clear engine, write-first read and free-way finder.
// The clear sweep owns the single storage write port while busy; port traffic is dropped.
module way_bits_array
    import way_bits_array_pkg::*;
#(
    parameter int SETS  = 8192,
    parameter int WAYS  = 4,
    parameter int BITS  = 1,
    localparam int IDX_W = $clog2(SETS)
) (
    input logic           clk,
    input logic           reset_n,
    way_bits_array_if.slave bus
);
    localparam int ROW_W = WAYS * BITS;
    localparam logic [IDX_W:0] SETS_X = (IDX_W+1)'(SETS);

    logic [0:0]        state;
    logic [IDX_W-1:0]  clr_ptr;
    logic              busy;
    logic              last;

    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [WAYS-1:0]   mem_wmask;
    logic [ROW_W-1:0]  mem_wdata;
    logic              mem_re;

    assign busy = (state == CLEAR);
    assign last = (clr_ptr == IDX_W'(SETS - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_ptr <= last ? '0 : clr_ptr + 1'b1;
                    if (last) state <= IDLE;
                end
                default: begin
                    if (bus.clr_req) begin
                        state   <= CLEAR;
                        clr_ptr <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.clr_done = busy && last;

    assign mem_we    = busy || bus.wr_en;
    assign mem_widx  = busy ? clr_ptr : bus.wr_index;
    assign mem_wmask = busy ? '1 : bus.wr_way_mask;
    assign mem_wdata = busy ? '0 : bus.wr_data;
    assign mem_re    = bus.rd_en && !busy;

    way_bits_mem #(.SETS(SETS), .WAYS(WAYS), .BITS(BITS), .IDX_W(IDX_W)) u_mem (
        .clk      (clk),
        .rst_n    (reset_n),
        .we       (mem_we),
        .wr_index (mem_widx),
        .wr_mask  (mem_wmask),
        .wr_data  (mem_wdata),
        .re       (mem_re),
        .rd_index (bus.rd_index),
        .rd_data  (bus.rd_q)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) bus.rd_valid <= 1'b0;
        else          bus.rd_valid <= mem_re;
    end

    logic [MAX_WAYS-1:0] vld_all;
    logic [MAX_WAYS-1:0] free_all;
    logic                unused_hi;

    assign vld_all         = row_valid(MAX_ROW'(bus.rd_q), BITS);
    assign free_all        = first_zero_onehot(vld_all, WAYS);
    assign bus.rd_free_way = free_all[WAYS-1:0];
    assign bus.rd_full     = &vld_all[WAYS-1:0];
    assign unused_hi       = ^{vld_all[MAX_WAYS-1:WAYS], free_all[MAX_WAYS-1:WAYS]};

    a_rd_index: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.rd_en && !busy) |-> ({1'b0, bus.rd_index} < SETS_X));
    a_wr_index: assert property (@(posedge clk) disable iff (!reset_n)
        (bus.wr_en && !busy) |-> ({1'b0, bus.wr_index} < SETS_X));
endmodule

// File: tb/tb_way_bits_array.sv
// Directed bench: stimulus pushes expected read results, a monitor pops on rd_valid.
module tb_way_bits_array;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    way_bits_array_if #(.WAYS(4), .BITS(1), .IDX_W(4)) b1();
    way_bits_array_if #(.WAYS(4), .BITS(2), .IDX_W(4)) b2();

    way_bits_array #(.SETS(16), .WAYS(4), .BITS(1)) dut1 (.clk(clk), .reset_n(reset_n), .bus(b1));
    way_bits_array #(.SETS(16), .WAYS(4), .BITS(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0]  q1[$];
    logic [12:0] q2[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [8:0]  e1;
        logic [12:0] e2;
        if (b1.rd_valid) begin
            if (q1.size() == 0) chk("dut1_unexpected_rd_valid", 32'(b1.rd_valid), 0);
            else begin
                e1 = q1.pop_front();
                chk("dut1_rd_q",    32'(b1.rd_q),        32'(e1[8:5]));
                chk("dut1_free",    32'(b1.rd_free_way), 32'(e1[4:1]));
                chk("dut1_full",    32'(b1.rd_full),     32'(e1[0]));
            end
        end
        if (b2.rd_valid) begin
            if (q2.size() == 0) chk("dut2_unexpected_rd_valid", 32'(b2.rd_valid), 0);
            else begin
                e2 = q2.pop_front();
                chk("dut2_rd_q",    32'(b2.rd_q),        32'(e2[12:5]));
                chk("dut2_free",    32'(b2.rd_free_way), 32'(e2[4:1]));
                chk("dut2_full",    32'(b2.rd_full),     32'(e2[0]));
            end
        end
    end

    task automatic op1(input logic we, input int wi, input logic [3:0] wm, input logic [3:0] wd,
                       input logic re, input int ri, input logic [3:0] eq, input logic [3:0] ef,
                       input logic efull);
        b1.wr_en = we; b1.wr_index = 4'(wi); b1.wr_way_mask = wm; b1.wr_data = wd;
        b1.rd_en = re; b1.rd_index = 4'(ri);
        if (re) q1.push_back({eq, ef, efull});
        @(negedge clk);
        b1.wr_en = 1'b0; b1.rd_en = 1'b0;
    endtask

    task automatic wr1(input int i, input logic [3:0] m, input logic [3:0] d);
        op1(1'b1, i, m, d, 1'b0, 0, 4'h0, 4'h0, 1'b0);
    endtask

    task automatic rd1(input int i, input logic [3:0] eq, input logic [3:0] ef, input logic efull);
        op1(1'b0, 0, 4'h0, 4'h0, 1'b1, i, eq, ef, efull);
    endtask

    task automatic wr2(input int i, input logic [3:0] m, input logic [7:0] d);
        b2.wr_en = 1'b1; b2.wr_index = 4'(i); b2.wr_way_mask = m; b2.wr_data = d;
        @(negedge clk);
        b2.wr_en = 1'b0;
    endtask

    task automatic rd2(input int i, input logic [7:0] eq, input logic [3:0] ef, input logic efull);
        b2.rd_en = 1'b1; b2.rd_index = 4'(i);
        q2.push_back({eq, ef, efull});
        @(negedge clk);
        b2.rd_en = 1'b0;
    endtask

    // Starts at a negedge where cycle 1 of a sweep is visible; optionally injects dropped traffic.
    task automatic measure_sweep(input logic inject, output int nb, output int nd, output int done_at);
        nb = 0; nd = 0; done_at = 0;
        for (int i = 1; i <= 40; i++) begin
            if (!b1.busy) break;
            nb++;
            if (b1.clr_done) begin nd++; done_at = i; end
            if (inject && i == 5) begin
                b1.wr_en = 1'b1; b1.wr_index = 4'd0; b1.wr_way_mask = 4'hF; b1.wr_data = 4'hF;
                b1.rd_en = 1'b1; b1.rd_index = 4'd0;
            end
            if (inject && i == 8)  b1.clr_req = 1'b1;
            if (inject && i == 16) begin b1.rd_en = 1'b1; b1.rd_index = 4'd4; end
            @(negedge clk);
            b1.wr_en = 1'b0; b1.rd_en = 1'b0; b1.clr_req = 1'b0;
        end
    endtask

    int nb, nd, da;

    initial begin
        b1.rd_en = 0; b1.rd_index = 0; b1.wr_en = 0; b1.wr_index = 0;
        b1.wr_way_mask = 0; b1.wr_data = 0; b1.clr_req = 0;
        b2.rd_en = 0; b2.rd_index = 0; b2.wr_en = 0; b2.wr_index = 0;
        b2.wr_way_mask = 0; b2.wr_data = 0; b2.clr_req = 0;

        // reset state, then power-up sweep
        @(negedge clk); @(negedge clk);
        chk("rst_busy",     32'(b1.busy), 1);
        chk("rst_rd_valid", 32'(b1.rd_valid), 0);
        chk("rst_rd_q",     32'(b1.rd_q), 0);
        chk("rst_clr_done", 32'(b1.clr_done), 0);
        reset_n = 1'b1;
        measure_sweep(1'b0, nb, nd, da);
        chk("sweep1_busy_cycles", 32'(nb), 16);
        chk("sweep1_done_pulses", 32'(nd), 1);
        chk("sweep1_done_cycle",  32'(da), 16);
        for (int i = 0; i < 16; i++) rd1(i, 4'b0000, 4'b0001, 1'b0);

        // masked writes accumulate
        wr1(5, 4'b0100, 4'b1111);
        rd1(5, 4'b0100, 4'b0001, 1'b0);
        wr1(5, 4'b0001, 4'b0001);
        rd1(5, 4'b0101, 4'b0010, 1'b0);

        // same-cycle write/read: write-first
        op1(1'b1, 3, 4'b1000, 4'b1000, 1'b1, 3, 4'b1000, 4'b0001, 1'b0);
        chk("wf_rd_valid", 32'(b1.rd_valid), 1);
        @(negedge clk);
        chk("hold_rd_valid", 32'(b1.rd_valid), 0);
        chk("hold_rd_q",     32'(b1.rd_q), 32'h8);

        // free-way / full
        wr1(7, 4'b0111, 4'b0111);
        rd1(7, 4'b0111, 4'b1000, 1'b0);
        wr1(7, 4'b1000, 4'b1000);
        rd1(7, 4'b1111, 4'b0000, 1'b1);
        wr1(7, 4'b0000, 4'b0000);
        rd1(7, 4'b1111, 4'b0000, 1'b1);

        // fill, then clear with traffic and a repeated clr_req during the sweep
        for (int i = 0; i < 16; i++) wr1(i, 4'b1111, 4'b1111);
        rd1(0,  4'b1111, 4'b0000, 1'b1);
        rd1(15, 4'b1111, 4'b0000, 1'b1);
        b1.clr_req = 1'b1;
        @(negedge clk);
        b1.clr_req = 1'b0;
        measure_sweep(1'b1, nb, nd, da);
        chk("sweep2_busy_cycles", 32'(nb), 16);
        chk("sweep2_done_pulses", 32'(nd), 1);
        chk("sweep2_done_cycle",  32'(da), 16);
        for (int i = 0; i < 16; i++) rd1(i, 4'b0000, 4'b0001, 1'b0);

        // reset mid-sweep at clr_ptr=7
        wr1(12, 4'b1111, 4'b1111);
        b1.clr_req = 1'b1;
        @(negedge clk);
        b1.clr_req = 1'b0;
        for (int i = 0; i < 7; i++) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrst_busy",     32'(b1.busy), 1);
        chk("midrst_rd_valid", 32'(b1.rd_valid), 0);
        chk("midrst_clr_done", 32'(b1.clr_done), 0);
        @(negedge clk);
        reset_n = 1'b1;
        measure_sweep(1'b0, nb, nd, da);
        chk("sweep3_busy_cycles", 32'(nb), 16);
        chk("sweep3_done_pulses", 32'(nd), 1);
        chk("sweep3_done_cycle",  32'(da), 16);
        rd1(12, 4'b0000, 4'b0001, 1'b0);

        // BITS=2 instance: valid is bit 0 of each 2-bit way
        wr2(5, 4'b0100, 8'hFF);
        rd2(5, 8'h30, 4'b0001, 1'b0);
        wr2(5, 4'b0001, 8'h02);
        rd2(5, 8'h32, 4'b0001, 1'b0);
        wr2(5, 4'b0001, 8'h03);
        rd2(5, 8'h33, 4'b0010, 1'b0);
        wr2(5, 4'b1010, 8'hFF);
        rd2(5, 8'hFF, 4'b0000, 1'b1);

        @(negedge clk); @(negedge clk);
        chk("q1_drained", 32'(q1.size()), 0);
        chk("q2_drained", 32'(q2.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
